// File: rtl/store_drain.sv
// rtl/store_drain.sv - one-entry store drain buffer between store queue and D-cache write port
// Optional feature macro: STORE_DRAIN_TAG_CHECK_EN (commit-tag FIFO and sticky tag_err_o)
module store_drain #(
    parameter int ROB_IDX_WIDTH = 6,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SQ_DEPTH      = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             flush_i,
    input  logic                             commit_valid_i,
    input  logic [ROB_IDX_WIDTH-1:0]         commit_rob_tag_i,
    input  logic                             sq_head_valid_i,
    input  logic [ROB_IDX_WIDTH-1:0]         sq_head_rob_tag_i,
    input  logic [ADDR_WIDTH-1:0]            sq_head_addr_i,
    input  logic [DATA_WIDTH-1:0]            sq_head_data_i,
    input  logic [DATA_WIDTH/8-1:0]          sq_head_be_i,
    output logic                             sq_pop_valid_o,
    output logic                             mem_req_valid_o,
    input  logic                             mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_req_data_o,
    output logic [DATA_WIDTH/8-1:0]          mem_req_be_o,
    input  logic                             mem_resp_valid_i,
    output logic [$clog2(SQ_DEPTH+1)-1:0]    pending_o,
    output logic                             drain_idle_o,
    output logic                             tag_err_o
);

    localparam int CNT_W = $clog2(SQ_DEPTH + 1);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(SQ_DEPTH);
    localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_pend;
    logic                     w_pop;
    logic                     w_req_valid;

    logic [ADDR_WIDTH-1:0]    r_buf_addr;
    logic [DATA_WIDTH-1:0]    r_buf_data;
    logic [BE_W-1:0]          r_buf_be;
    logic [ROB_IDX_WIDTH-1:0] r_buf_tag;

    // FSM state register; reset drops any in-flight store immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control decode; pop only uses the registered count, so a
    // commit in the same cycle cannot release its own store
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop = sq_head_valid_i && (r_pend != '0);
                if (w_pop) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_req_valid = 1'b1;
                if (mem_req_ready_i) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_resp_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Committed-but-not-popped counter; flush never touches it because
    // committed stores are architectural
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend <= '0;
        end else if (commit_valid_i && !w_pop) begin
            r_pend <= r_pend + PEND_ONE;
        end else if (!commit_valid_i && w_pop) begin
            r_pend <= r_pend - PEND_ONE;
        end
    end

    // Drain buffer captures the SQ head on pop and holds it until the write completes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buf_addr <= '0;
            r_buf_data <= '0;
            r_buf_be   <= '0;
            r_buf_tag  <= '0;
        end else if (w_pop) begin
            r_buf_addr <= sq_head_addr_i;
            r_buf_data <= sq_head_data_i;
            r_buf_be   <= sq_head_be_i;
            r_buf_tag  <= sq_head_rob_tag_i;
        end
    end

    assign sq_pop_valid_o  = w_pop;
    assign mem_req_valid_o = w_req_valid;
    assign mem_req_addr_o  = w_req_valid ? r_buf_addr : '0;
    assign mem_req_data_o  = w_req_valid ? r_buf_data : '0;
    assign mem_req_be_o    = w_req_valid ? r_buf_be   : '0;
    assign pending_o       = r_pend;
    assign drain_idle_o    = (r_pend == '0) && (r_state == S_IDLE);

    // The buffered tag is kept for debug visibility; flush only matters upstream
    logic w_unused_misc;
    assign w_unused_misc = ^{flush_i, r_buf_tag};

`ifdef STORE_DRAIN_TAG_CHECK_EN
    localparam int PTR_W = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SQ_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ROB_IDX_WIDTH-1:0] r_tag_mem [SQ_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic                     r_tag_err;

    // Tag FIFO storage; occupancy mirrors r_pend so no separate count is kept
    always_ff @(posedge clk_i) begin
        if (commit_valid_i) begin
            r_tag_mem[r_wr_ptr] <= commit_rob_tag_i;
        end
    end

    // FIFO pointers wrap explicitly so non-power-of-two depths work
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (commit_valid_i) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Sticky mismatch flag; a bad tag is reported but the store still drains
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tag_err <= 1'b0;
        end else if (w_pop && (r_tag_mem[r_rd_ptr] != sq_head_rob_tag_i)) begin
            r_tag_err <= 1'b1;
        end
    end

    assign tag_err_o = r_tag_err;
`else
    logic w_unused_tags;
    assign w_unused_tags = ^{commit_rob_tag_i, sq_head_rob_tag_i};
    assign tag_err_o     = 1'b0;
`endif

    // The ROB must never retire more stores than the SQ can hold
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(commit_valid_i && (r_pend == PEND_MAX) && !w_pop));

    // A pop always consumes a counted commit
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_pop && (r_pend == '0)));

endmodule

// File: tb/tb_store_drain.sv
// tb/tb_store_drain.sv - directed table-driven bench for store_drain
module tb_store_drain;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        commit_valid_i;
    logic [5:0]  commit_rob_tag_i;
    logic        sq_head_valid_i;
    logic [5:0]  sq_head_rob_tag_i;
    logic [31:0] sq_head_addr_i;
    logic [31:0] sq_head_data_i;
    logic [3:0]  sq_head_be_i;
    logic        sq_pop_valid_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic [31:0] mem_req_data_o;
    logic [3:0]  mem_req_be_o;
    logic        mem_resp_valid_i;
    logic [4:0]  pending_o;
    logic        drain_idle_o;
    logic        tag_err_o;

`ifdef STORE_DRAIN_TAG_CHECK_EN
    localparam bit TAGCHK = 1'b1;
`else
    localparam bit TAGCHK = 1'b0;
`endif

    store_drain #(
        .ROB_IDX_WIDTH(6),
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .SQ_DEPTH     (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .commit_valid_i   (commit_valid_i),
        .commit_rob_tag_i (commit_rob_tag_i),
        .sq_head_valid_i  (sq_head_valid_i),
        .sq_head_rob_tag_i(sq_head_rob_tag_i),
        .sq_head_addr_i   (sq_head_addr_i),
        .sq_head_data_i   (sq_head_data_i),
        .sq_head_be_i     (sq_head_be_i),
        .sq_pop_valid_o   (sq_pop_valid_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_data_o   (mem_req_data_o),
        .mem_req_be_o     (mem_req_be_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .pending_o        (pending_o),
        .drain_idle_o     (drain_idle_o),
        .tag_err_o        (tag_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        bit cv;
        bit hv;
        int hs;
        bit rdy;
        bit rsp;
        bit fl;
        bit e_pop;
        int es;
        int e_pend;
        bit e_idle;
    } vec_t;

    int checks;
    int errors;

    logic [31:0] s_addr [8];
    logic [31:0] s_data [8];
    logic [3:0]  s_be   [8];

    vec_t vecs [$];

    function automatic vec_t mk(bit cv, bit hv, int hs, bit rdy, bit rsp, bit fl,
                                bit e_pop, int es, int e_pend, bit e_idle);
        vec_t v;
        v.cv = cv; v.hv = hv; v.hs = hs; v.rdy = rdy; v.rsp = rsp; v.fl = fl;
        v.e_pop = e_pop; v.es = es; v.e_pend = e_pend; v.e_idle = e_idle;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_head(input int hs);
        sq_head_addr_i = s_addr[hs];
        sq_head_data_i = s_data[hs];
        sq_head_be_i   = s_be[hs];
    endtask

    task automatic idle_inputs();
        commit_valid_i   = 1'b0;
        sq_head_valid_i  = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        flush_i          = 1'b0;
        set_head(0);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_req(input string nm, input int es);
        chk({nm, "_req"},  32'(mem_req_valid_o), 32'(es != 0));
        chk({nm, "_addr"}, mem_req_addr_o, s_addr[es]);
        chk({nm, "_data"}, mem_req_data_o, s_data[es]);
        chk({nm, "_be"},   32'(mem_req_be_o), 32'(s_be[es]));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        s_addr[0] = 32'h0;    s_data[0] = 32'h0;        s_be[0] = 4'h0;
        s_addr[1] = 32'h1000; s_data[1] = 32'hDEADBEEF; s_be[1] = 4'hF;
        s_addr[2] = 32'h2000; s_data[2] = 32'h11111111; s_be[2] = 4'h1;
        s_addr[3] = 32'h2004; s_data[3] = 32'h22222222; s_be[3] = 4'h3;
        s_addr[4] = 32'h2008; s_data[4] = 32'h33333333; s_be[4] = 4'hC;
        s_addr[5] = 32'h3000; s_data[5] = 32'hCAFEF00D; s_be[5] = 4'hF;
        s_addr[6] = 32'h4000; s_data[6] = 32'hA5A5A5A5; s_be[6] = 4'h6;
        s_addr[7] = 32'h4010; s_data[7] = 32'h5A5A5A5A; s_be[7] = 4'h9;

        // single store: commit, pop, request, response, idle at cycle 5
        vecs.push_back(mk(1,1,1, 0,0,0, 0,0,0,1));
        vecs.push_back(mk(0,1,1, 0,0,0, 1,0,1,0));
        vecs.push_back(mk(0,0,0, 1,0,0, 0,1,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0,1));
        // three commits then three drains in order
        vecs.push_back(mk(1,0,0, 0,0,0, 0,0,0,1));
        vecs.push_back(mk(1,0,0, 0,0,0, 0,0,1,0));
        vecs.push_back(mk(1,0,0, 0,0,0, 0,0,2,0));
        vecs.push_back(mk(0,1,2, 0,0,0, 1,0,3,0));
        vecs.push_back(mk(0,1,3, 1,0,0, 0,2,2,0));
        vecs.push_back(mk(0,1,3, 0,1,0, 0,0,2,0));
        vecs.push_back(mk(0,1,3, 0,0,0, 1,0,2,0));
        vecs.push_back(mk(0,1,4, 1,0,0, 0,3,1,0));
        vecs.push_back(mk(0,1,4, 0,1,0, 0,0,1,0));
        vecs.push_back(mk(0,1,4, 0,0,0, 1,0,1,0));
        vecs.push_back(mk(0,0,0, 1,0,0, 0,4,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0,1));
        // flush in RESP; response during handshake and in IDLE are ignored
        vecs.push_back(mk(1,1,5, 0,0,0, 0,0,0,1));
        vecs.push_back(mk(0,1,5, 0,0,0, 1,0,1,0));
        vecs.push_back(mk(0,0,0, 1,1,0, 0,5,0,0));
        vecs.push_back(mk(0,0,0, 0,0,1, 0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,1, 0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0, 0,0,0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0,1));
        // ready held low 7 cycles with a second committed store waiting
        vecs.push_back(mk(1,1,6, 0,0,0, 0,0,0,1));
        vecs.push_back(mk(1,1,6, 0,0,0, 1,0,1,0));
        for (int k = 0; k < 7; k++) begin
            vecs.push_back(mk(0,1,7, 0,0,0, 0,6,1,0));
        end
        vecs.push_back(mk(0,1,7, 1,0,0, 0,6,1,0));
        vecs.push_back(mk(0,1,7, 0,1,0, 0,0,1,0));
        vecs.push_back(mk(0,1,7, 0,0,0, 1,0,1,0));
        vecs.push_back(mk(0,0,0, 1,0,0, 0,7,0,0));
        vecs.push_back(mk(0,0,0, 0,1,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 0,0,0,1));

        // reset values
        rst_ni = 1'b0;
        commit_rob_tag_i  = 6'd0;
        sq_head_rob_tag_i = 6'd0;
        idle_inputs();
        #1;
        chk("rst_pop",  32'(sq_pop_valid_o), 32'd0);
        chk_req("rst", 0);
        chk("rst_pend", 32'(pending_o), 32'd0);
        chk("rst_idle", 32'(drain_idle_o), 32'd1);
        chk("rst_err",  32'(tag_err_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // head valid without a commit never pops
        sq_head_valid_i = 1'b1;
        set_head(1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            chk($sformatf("nocommit%0d_pop", c),  32'(sq_pop_valid_o), 32'd0);
            chk($sformatf("nocommit%0d_idle", c), 32'(drain_idle_o), 32'd1);
            step();
        end
        idle_inputs();
        step();

        // vector table
        for (int i = 0; i < vecs.size(); i++) begin
            commit_valid_i   = vecs[i].cv;
            sq_head_valid_i  = vecs[i].hv;
            set_head(vecs[i].hs);
            mem_req_ready_i  = vecs[i].rdy;
            mem_resp_valid_i = vecs[i].rsp;
            flush_i          = vecs[i].fl;
            @(negedge clk_i);
            chk($sformatf("v%0d_pop", i),  32'(sq_pop_valid_o), 32'(vecs[i].e_pop));
            chk_req($sformatf("v%0d", i), vecs[i].es);
            chk($sformatf("v%0d_pend", i), 32'(pending_o), 32'(vecs[i].e_pend));
            chk($sformatf("v%0d_idle", i), 32'(drain_idle_o), 32'(vecs[i].e_idle));
            chk($sformatf("v%0d_err", i),  32'(tag_err_o), 32'd0);
            step();
        end
        idle_inputs();

        // reset in the middle of a request discards everything at once
        commit_valid_i = 1'b1;
        step();
        step();
        commit_valid_i  = 1'b0;
        sq_head_valid_i = 1'b1;
        set_head(1);
        step();
        sq_head_valid_i = 1'b0;
        @(negedge clk_i);
        chk("mid_req_before", 32'(mem_req_valid_o), 32'd1);
        chk("mid_pend_before", 32'(pending_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk_req("mid_rst", 0);
        chk("mid_rst_pend", 32'(pending_o), 32'd0);
        chk("mid_rst_idle", 32'(drain_idle_o), 32'd1);
        step();
        rst_ni = 1'b1;
        sq_head_valid_i = 1'b1;
        @(negedge clk_i);
        chk("mid_after_pop",  32'(sq_pop_valid_o), 32'd0);
        chk("mid_after_idle", 32'(drain_idle_o), 32'd1);
        step();
        idle_inputs();
        step();

        // tag mismatch: flagged when the check is built in, store still written
        commit_valid_i   = 1'b1;
        commit_rob_tag_i = 6'd3;
        step();
        commit_valid_i    = 1'b0;
        commit_rob_tag_i  = 6'd0;
        sq_head_valid_i   = 1'b1;
        sq_head_rob_tag_i = 6'd4;
        set_head(1);
        @(negedge clk_i);
        chk("tag_pop", 32'(sq_pop_valid_o), 32'd1);
        chk("tag_err_pre", 32'(tag_err_o), 32'd0);
        step();
        sq_head_valid_i   = 1'b0;
        sq_head_rob_tag_i = 6'd0;
        set_head(0);
        mem_req_ready_i   = 1'b1;
        @(negedge clk_i);
        chk_req("tag", 1);
        chk("tag_err_set", 32'(tag_err_o), 32'(TAGCHK));
        step();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        step();
        mem_resp_valid_i = 1'b0;
        @(negedge clk_i);
        chk("tag_err_sticky", 32'(tag_err_o), 32'(TAGCHK));
        chk("tag_done_idle", 32'(drain_idle_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("tag_err_rst", 32'(tag_err_o), 32'd0);
        step();
        rst_ni = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
